// File: rtl/alu_serial_sequencer.sv
// Bit-serial ALU controller: one 1-bit ALU slice is stepped WIDTH times, LSB first,
// then the set-less-than fixup and flags are applied in a single DONE cycle.
module alu_serial_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       command,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carryout,
   output logic             overflow,
   output logic             zero
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [2:0] CMD_ADD  = 3'b000;
   localparam logic [2:0] CMD_SUB  = 3'b001;
   localparam logic [2:0] CMD_XOR  = 3'b010;
   localparam logic [2:0] CMD_SLT  = 3'b011;
   localparam logic [2:0] CMD_AND  = 3'b100;
   localparam logic [2:0] CMD_NAND = 3'b101;
   localparam logic [2:0] CMD_NOR  = 3'b110;
   localparam logic [2:0] CMD_OR   = 3'b111;

   logic [1:0]       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [2:0]       cmd_q, cmd_d;
   logic [WIDTH-1:0] a_sr_q, a_sr_d, b_sr_q, b_sr_d, res_sr_q, res_sr_d;
   logic             carry_q, carry_d, zchain_q, zchain_d;
   logic             cmsb_q, cmsb_d, sign_q, sign_d;
   logic             busy_q, busy_d, done_q, done_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             carryout_q, carryout_d, overflow_q, overflow_d, zero_q, zero_d;

   logic slice_invtb, slice_a, slice_b, slice_bb, slice_sum, slice_cout, slice_res, slice_zout;
   logic ovf_raw, slt_bit;

   // One-bit ALU slice operating on the current LSB of the operand shift registers.
   always_comb begin
      slice_invtb = (cmd_q == CMD_SUB) || (cmd_q == CMD_SLT);
      slice_a     = a_sr_q[0];
      slice_b     = b_sr_q[0];
      slice_bb    = slice_b ^ slice_invtb;
      slice_sum   = slice_a ^ slice_bb ^ carry_q;
      slice_cout  = (slice_a & slice_bb) | (carry_q & (slice_a ^ slice_bb));
      case (cmd_q)
         CMD_XOR:  slice_res = slice_a ^ slice_b;
         CMD_AND:  slice_res = slice_a & slice_b;
         CMD_NAND: slice_res = ~(slice_a & slice_b);
         CMD_NOR:  slice_res = ~(slice_a | slice_b);
         CMD_OR:   slice_res = slice_a | slice_b;
         default:  slice_res = slice_sum;
      endcase
      slice_zout = zchain_q | slice_res;
   end

   assign ovf_raw = cmsb_q ^ carry_q;
   assign slt_bit = sign_q ^ ovf_raw;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      cmd_d      = cmd_q;
      a_sr_d     = a_sr_q;
      b_sr_d     = b_sr_q;
      res_sr_d   = res_sr_q;
      carry_d    = carry_q;
      zchain_d   = zchain_q;
      cmsb_d     = cmsb_q;
      sign_d     = sign_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      result_d   = result_q;
      carryout_d = carryout_q;
      overflow_d = overflow_q;
      zero_d     = zero_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_sr_d   = a;
               b_sr_d   = b;
               cmd_d    = command;
               cnt_d    = '0;
               carry_d  = (command == CMD_SUB) || (command == CMD_SLT);
               zchain_d = 1'b0;
               busy_d   = 1'b1;
               state_d  = S_RUN;
            end
         end
         S_RUN: begin
            a_sr_d   = a_sr_q >> 1;
            b_sr_d   = b_sr_q >> 1;
            res_sr_d = {slice_res, res_sr_q[WIDTH-1:1]};
            carry_d  = slice_cout;
            zchain_d = slice_zout;
            if (cnt_q == LAST_BIT) begin
               cmsb_d  = carry_q;
               sign_d  = slice_res;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DONE: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
            if (cmd_q == CMD_ADD || cmd_q == CMD_SUB) begin
               result_d   = res_sr_q;
               carryout_d = carry_q;
               overflow_d = ovf_raw;
               zero_d     = ~zchain_q;
            end else if (cmd_q == CMD_SLT) begin
               result_d   = {{(WIDTH-1){1'b0}}, slt_bit};
               carryout_d = 1'b0;
               overflow_d = 1'b0;
               zero_d     = ~slt_bit;
            end else begin
               result_d   = res_sr_q;
               carryout_d = 1'b0;
               overflow_d = 1'b0;
               zero_d     = ~zchain_q;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         cmd_q      <= '0;
         a_sr_q     <= '0;
         b_sr_q     <= '0;
         res_sr_q   <= '0;
         carry_q    <= 1'b0;
         zchain_q   <= 1'b0;
         cmsb_q     <= 1'b0;
         sign_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         result_q   <= '0;
         carryout_q <= 1'b0;
         overflow_q <= 1'b0;
         zero_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         cmd_q      <= cmd_d;
         a_sr_q     <= a_sr_d;
         b_sr_q     <= b_sr_d;
         res_sr_q   <= res_sr_d;
         carry_q    <= carry_d;
         zchain_q   <= zchain_d;
         cmsb_q     <= cmsb_d;
         sign_q     <= sign_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         result_q   <= result_d;
         carryout_q <= carryout_d;
         overflow_q <= overflow_d;
         zero_q     <= zero_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign result   = result_q;
   assign carryout = carryout_q;
   assign overflow = overflow_q;
   assign zero     = zero_q;

endmodule

// File: tb/tb_alu_serial_sequencer.sv
// Scoreboard bench: the driver pushes model predictions, a monitor pops and compares on done.
module tb_alu_serial_sequencer;

   localparam int W = 32;

   typedef struct packed {
      logic [W-1:0] res;
      logic         co;
      logic         ov;
      logic         z;
      logic [31:0]  cyc;
   } exp_t;

   logic         clk, rst_n, start;
   logic [2:0]   command;
   logic [W-1:0] a, b;
   logic         busy, done, carryout, overflow, zero;
   logic [W-1:0] result;

   int           checks = 0;
   int           errors = 0;
   logic [31:0]  cyc = 0;
   int           txn = 0;
   exp_t         sb[$];
   logic [W-1:0] prev_res = '0;
   logic         done_prev = 1'b0;

   alu_serial_sequencer #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .command(command), .a(a), .b(b),
      .busy(busy), .done(done), .result(result), .carryout(carryout),
      .overflow(overflow), .zero(zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
      end
   endtask

   // Reference model: plain two's-complement arithmetic and signed compare.
   function automatic exp_t model(input logic [2:0] c, input logic [W-1:0] x, input logic [W-1:0] y);
      exp_t e;
      logic [W:0] s;
      e = '0;
      case (c)
         3'b000: begin
            s = {1'b0, x} + {1'b0, y};
            e.res = s[W-1:0];
            e.co = s[W];
            e.ov = (x[W-1] == y[W-1]) && (e.res[W-1] != x[W-1]);
         end
         3'b001: begin
            s = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
            e.res = s[W-1:0];
            e.co = s[W];
            e.ov = (x[W-1] != y[W-1]) && (e.res[W-1] != x[W-1]);
         end
         3'b010: e.res = x ^ y;
         3'b011: e.res = ($signed(x) < $signed(y)) ? W'(1) : '0;
         3'b100: e.res = x & y;
         3'b101: e.res = ~(x & y);
         3'b110: e.res = ~(x | y);
         default: e.res = x | y;
      endcase
      e.z = (e.res == '0);
      return e;
   endfunction

   // Monitor: compares every done pulse against the oldest prediction.
   always @(negedge clk) begin
      exp_t e;
      if (done) begin
         chk("done_single_cycle", 32'(done_prev), 32'd0);
         if (sb.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            txn++;
            $display("txn %0d: result=%h co=%b ov=%b z=%b (expect %h %b %b %b)",
                     txn, result, carryout, overflow, zero, e.res, e.co, e.ov, e.z);
            chk("result", result, e.res);
            chk("carryout", 32'(carryout), 32'(e.co));
            chk("overflow", 32'(overflow), 32'(e.ov));
            chk("zero", 32'(zero), 32'(e.z));
            chk("latency", cyc, e.cyc);
         end
      end
      done_prev <= done;
   end

   // Issues one operation at the current negedge and follows it to its done pulse.
   task automatic do_op(input logic [2:0] c, input logic [W-1:0] x, input logic [W-1:0] y, input bit ign);
      exp_t e;
      int   busy_n = 0;
      bit   hold_ok = 1'b1;
      bit   seen = 1'b0;
      e = model(c, x, y);
      e.cyc = cyc + W + 2;
      sb.push_back(e);
      start = 1'b1;
      command = c;
      a = x;
      b = y;
      for (int n = 1; n <= W + 10 && !seen; n++) begin
         @(negedge clk);
         start = 1'b0;
         command = 3'($urandom);
         a = $urandom;
         b = $urandom;
         if (done) begin
            seen = 1'b1;
            chk("busy_low_at_done", 32'(busy), 32'd0);
         end else begin
            if (busy) busy_n++;
            if (result !== prev_res) hold_ok = 1'b0;
            if (ign && (n == 5 || n == W + 1)) start = 1'b1;
         end
      end
      chk("done_seen", 32'(seen), 32'd1);
      chk("busy_cycles", 32'(busy_n), 32'(W + 1));
      chk("result_held_during_run", 32'(hold_ok), 32'd1);
      prev_res = e.res;
   endtask

   initial begin
      int dn;
      rst_n = 1'b0;
      start = 1'b0;
      command = '0;
      a = '0;
      b = '0;
      repeat (3) @(negedge clk);
      chk("reset_result", result, 32'd0);
      chk("reset_flags", {28'd0, busy, done, carryout, overflow}, 32'd0);
      chk("reset_zero", 32'(zero), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      do_op(3'b000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
      do_op(3'b001, 32'd5, 32'd5, 1'b0);
      do_op(3'b001, 32'd0, 32'd1, 1'b0);
      do_op(3'b011, 32'hFFFF_FFFF, 32'd1, 1'b0);
      do_op(3'b011, 32'h8000_0000, 32'd1, 1'b0);
      do_op(3'b011, 32'd1, 32'h8000_0000, 1'b0);
      for (int c = 2; c < 8; c++) begin
         if (c != 3) do_op(3'(c), 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0);
      end
      do_op(3'b100, 32'h1234_5678, ~32'h1234_5678, 1'b0);
      do_op(3'b000, 32'h0000_1111, 32'h0000_2222, 1'b1);
      do_op(3'b001, 32'h8000_0000, 32'h0000_0001, 1'b1);

      // Give the held outputs nonzero content before aborting an operation.
      do_op(3'b000, 32'hFFFF_FFFF, 32'd2, 1'b0);
      start = 1'b1;
      command = 3'b000;
      a = 32'h0F0F_0F0F;
      b = 32'h1111_1111;
      @(negedge clk);
      start = 1'b0;
      repeat (11) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("async_reset_result", result, 32'd0);
      chk("async_reset_flags", {28'd0, busy, done, carryout, overflow}, 32'd0);
      chk("async_reset_zero", 32'(zero), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      dn = 0;
      repeat (W + 5) begin
         @(negedge clk);
         if (done) dn++;
      end
      chk("no_done_after_abort", 32'(dn), 32'd0);
      prev_res = '0;
      do_op(3'b000, 32'd3, 32'd4, 1'b0);

      for (int i = 0; i < 40; i++) begin
         logic [W-1:0] ra, rb;
         ra = $urandom;
         rb = $urandom;
         if (i % 5 == 0) rb = ra;
         if (i % 7 == 0) ra = {1'b1, 31'($urandom_range(0, 3))};
         do_op(3'($urandom_range(0, 7)), ra, rb, ($urandom_range(0, 3) == 0));
      end

      repeat (5) @(negedge clk);
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
